// File: rtl/cvxif_delay_alu_pkg.sv
// Shared ALU op encoding and default geometry for the delayed-ALU coprocessor slice.
// No logic of its own; latency/backpressure are properties of the modules that import it.
package cvxif_delay_alu_pkg;

  typedef enum logic [1:0] {
    OP_XOR = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_ADD = 2'b11
  } alu_op_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 1;
  localparam int unsigned DEF_ID_W  = 3;

endpackage

// File: rtl/cvxif_delay_alu_stage.sv
// One elastic pipeline register (valid, data, tag); one cycle per stage.
// Captures upstream whenever load_rdy is high (empty or draining), otherwise holds.
module cvxif_delay_alu_stage
  import cvxif_delay_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ID_W  = DEF_ID_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             load_rdy,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  input  logic [ID_W-1:0]  in_id,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  output logic [ID_W-1:0]  out_id
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      out_id  <= '0;
    end else begin
      if (flush_i) begin
        out_vld <= 1'b0;
      end else if (load_rdy) begin
        out_vld <= in_vld;
      end
      // Bubbles leave the payload untouched to avoid needless toggling.
      if (load_rdy && in_vld) begin
        out_dat <= in_dat;
        out_id  <= in_id;
      end
    end
  end

endmodule

// File: rtl/cvxif_delay_alu.sv
// Tagged XOR/AND/OR/ADD unit behind a DEPTH-stage elastic pipeline; DEPTH cycles latency.
// Valid/ready at both ends, bubble-free; a full stalled pipeline drops in_ready_o, flush kills all.
module cvxif_delay_alu
  import cvxif_delay_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned ID_W  = DEF_ID_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [1:0]                 op_i,
  input  logic [WIDTH-1:0]           rs1_i,
  input  logic [WIDTH-1:0]           rs2_i,
  input  logic [ID_W-1:0]            id_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           result_o,
  output logic [ID_W-1:0]            id_o,
  output logic [$clog2(DEPTH+1)-1:0] inflight_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] stg_vld;
  logic [DEPTH-1:0] stg_rdy;
  logic [WIDTH-1:0] stg_dat [DEPTH];
  logic [ID_W-1:0]  stg_id  [DEPTH];
  logic [WIDTH-1:0] alu_dat;
  logic             in_acc;
  logic [CNT_W-1:0] vld_cnt;

  always_comb begin
    alu_dat = '0;
    case (alu_op_e'(op_i))
      OP_XOR: alu_dat = rs1_i ^ rs2_i;
      OP_AND: alu_dat = rs1_i & rs2_i;
      OP_OR:  alu_dat = rs1_i | rs2_i;
      OP_ADD: alu_dat = rs1_i + rs2_i;
      default: alu_dat = '0;
    endcase
  end

  // A stage may load when any stage at or after it is empty, or the consumer drains the tail;
  // evaluated from registered valids so no ready chain ripples through the stages.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stg_rdy[k] = out_ready_i;
      for (int j = k; j < DEPTH; j++) begin
        if (!stg_vld[j]) stg_rdy[k] = 1'b1;
      end
    end
  end

  assign in_ready_o = stg_rdy[0] & ~flush_i & ~rst_i;
  assign in_acc     = in_valid_i & in_ready_o;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_vld;
    logic [WIDTH-1:0] up_dat;
    logic [ID_W-1:0]  up_id;

    if (k == 0) begin : g_head
      assign up_vld = in_acc;
      assign up_dat = alu_dat;
      assign up_id  = id_i;
    end else begin : g_body
      assign up_vld = stg_vld[k-1];
      assign up_dat = stg_dat[k-1];
      assign up_id  = stg_id[k-1];
    end

    cvxif_delay_alu_stage #(
      .WIDTH (WIDTH),
      .ID_W  (ID_W)
    ) u_stage (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .flush_i  (flush_i),
      .load_rdy (stg_rdy[k]),
      .in_vld   (up_vld),
      .in_dat   (up_dat),
      .in_id    (up_id),
      .out_vld  (stg_vld[k]),
      .out_dat  (stg_dat[k]),
      .out_id   (stg_id[k])
    );
  end

  always_comb begin
    vld_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      vld_cnt = vld_cnt + CNT_W'(stg_vld[k]);
    end
  end

  assign inflight_o  = vld_cnt;
  assign out_valid_o = stg_vld[DEPTH-1];
  assign result_o    = out_valid_o ? stg_dat[DEPTH-1] : '0;
  assign id_o        = out_valid_o ? stg_id[DEPTH-1] : '0;

endmodule

// File: tb/tb_cvxif_delay_alu.sv
// Bench for cvxif_delay_alu: DEPTH=3 instance (u=0) for directed cases, DEPTH=1 instance (u=1) for stress.
// A transaction-level model (in-order queue plus acceptance time) is checked every cycle.
module tb_cvxif_delay_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  in_valid, in_ready, out_valid, out_ready, flush;
  logic [1:0]  op     [2];
  logic [31:0] rs1    [2];
  logic [31:0] rs2    [2];
  logic [31:0] result [2];
  logic [2:0]  id_in  [2];
  logic [2:0]  id_out [2];
  logic [1:0]  infl3;
  logic [0:0]  infl1;

  logic [31:0] m_res [2][64];
  logic [2:0]  m_id  [2][64];
  int          m_acc [2][64];
  int          m_hd  [2];
  int          m_tl  [2];
  int          cyc;
  int          total;
  int          bad;

  always #5 clk = ~clk;

  cvxif_delay_alu #(.WIDTH(32), .DEPTH(3), .ID_W(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .op_i(op[0]), .rs1_i(rs1[0]), .rs2_i(rs2[0]), .id_i(id_in[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .result_o(result[0]), .id_o(id_out[0]), .inflight_o(infl3)
  );

  cvxif_delay_alu #(.WIDTH(32), .DEPTH(1), .ID_W(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .op_i(op[1]), .rs1_i(rs1[1]), .rs2_i(rs2[1]), .id_i(id_in[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .result_o(result[1]), .id_o(id_out[1]), .inflight_o(infl1)
  );

  function automatic logic [31:0] ref_alu(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    case (o)
      2'd0:    return a ^ b;
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return a + b;
    endcase
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Items in flight = accepted minus delivered; the oldest item sits at the output
  // once DEPTH-1 edges have passed since it was accepted, since nothing is ahead of it.
  task automatic model_check();
    for (int u = 0; u < 2; u++) begin
      int          dep;
      int          cnt;
      int          h;
      int          t;
      int          act_inf;
      logic        erdy;
      logic        eov;
      logic [31:0] eres;
      logic [2:0]  eid;
      dep = (u == 0) ? 3 : 1;
      if (rst) m_hd[u] = m_tl[u];
      cnt  = m_tl[u] - m_hd[u];
      h    = m_hd[u] % 64;
      erdy = !rst && !flush[u] && (cnt < dep || out_ready[u]);
      eov  = !rst && cnt > 0 && (cyc - m_acc[u][h]) >= dep - 1;
      eres = eov ? m_res[u][h] : 32'd0;
      eid  = eov ? m_id[u][h] : 3'd0;
      act_inf = (u == 0) ? int'(infl3) : int'(infl1);
      chk($sformatf("u%0d in_ready", u), 64'(in_ready[u]), 64'(erdy));
      chk($sformatf("u%0d out_valid", u), 64'(out_valid[u]), 64'(eov));
      chk($sformatf("u%0d result", u), 64'(result[u]), 64'(eres));
      chk($sformatf("u%0d id", u), 64'(id_out[u]), 64'(eid));
      chk($sformatf("u%0d inflight", u), 64'(act_inf), 64'(cnt));
      if (!rst) begin
        if (flush[u]) begin
          m_hd[u] = m_tl[u];
        end else begin
          if (eov && out_ready[u]) m_hd[u]++;
          if (in_valid[u] && erdy) begin
            t = m_tl[u] % 64;
            m_res[u][t] = ref_alu(op[u], rs1[u], rs2[u]);
            m_id[u][t]  = id_in[u];
            m_acc[u][t] = cyc + 1;
            m_tl[u]++;
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int u, logic v, logic [1:0] o, logic [31:0] a, logic [31:0] b, logic [2:0] i);
    in_valid[u] = v;
    op[u]       = o;
    rs1[u]      = a;
    rs2[u]      = b;
    id_in[u]    = i;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    for (int u = 0; u < 2; u++) begin
      m_hd[u] = 0; m_tl[u] = 0;
      drive(u, 1'b0, 2'd0, 32'd0, 32'd0, 3'd0);
    end
    flush = 2'b00;
    out_ready = 2'b11;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset in_ready", 64'(in_ready), 64'(2'b11));
    chk("reset out_valid", 64'(out_valid), 64'(2'b00));
    chk("reset inflight", 64'(infl3), 64'd0);

    // single XOR, DEPTH=3 latency
    drive(0, 1'b1, 2'd0, 32'hFFFF0000, 32'h0F0F0F0F, 3'd5);
    tick(); in_valid[0] = 1'b0;
    tick(); chk("xor early", 64'(out_valid[0]), 64'd0);
    tick();
    chk("xor valid", 64'(out_valid[0]), 64'd1);
    chk("xor result", 64'(result[0]), 64'hF0F00F0F);
    chk("xor id", 64'(id_out[0]), 64'd5);
    tick(); chk("xor one-shot", 64'(out_valid[0]), 64'd0);

    // back-to-back stream
    drive(0, 1'b1, 2'd3, 32'hFFFFFFFF, 32'h00000002, 3'd1); tick();
    drive(0, 1'b1, 2'd1, 32'hF0F0F0F0, 32'h3C3C3C3C, 3'd2); tick();
    drive(0, 1'b1, 2'd2, 32'h00000001, 32'h00000002, 3'd3); tick();
    in_valid[0] = 1'b0;
    chk("stream add", 64'(result[0]), 64'h1);
    chk("stream add id", 64'(id_out[0]), 64'd1);
    tick(); chk("stream and", 64'(result[0]), 64'h30303030);
    tick(); chk("stream or", 64'(result[0]), 64'h3);
    chk("stream or id", 64'(id_out[0]), 64'd3);
    tick(); chk("stream end", 64'(out_valid[0]), 64'd0);

    // fill under backpressure, then release with a simultaneous accept
    out_ready[0] = 1'b0;
    drive(0, 1'b1, 2'd0, 32'hA5A5A5A5, 32'hFFFFFFFF, 3'd0); tick();
    drive(0, 1'b1, 2'd3, 32'h7FFFFFFF, 32'h00000001, 3'd1); tick();
    drive(0, 1'b1, 2'd1, 32'h12345678, 32'h0000FFFF, 3'd2); tick();
    drive(0, 1'b1, 2'd2, 32'h00000100, 32'h00000011, 3'd3);
    chk("full in_ready", 64'(in_ready[0]), 64'd0);
    chk("full inflight", 64'(infl3), 64'd3);
    chk("full result", 64'(result[0]), 64'h5A5A5A5A);
    tick();
    chk("stall result", 64'(result[0]), 64'h5A5A5A5A);
    chk("stall id", 64'(id_out[0]), 64'd0);
    tick();
    chk("stall inflight", 64'(infl3), 64'd3);
    out_ready[0] = 1'b1;
    #1;
    chk("release in_ready", 64'(in_ready[0]), 64'd1);
    tick(); in_valid[0] = 1'b0;
    chk("drain r1", 64'(result[0]), 64'h80000000);
    tick(); chk("drain r2", 64'(result[0]), 64'h00005678);
    tick(); chk("drain r3", 64'(result[0]), 64'h00000111);
    chk("drain r3 id", 64'(id_out[0]), 64'd3);
    tick(); chk("drain empty", 64'(infl3), 64'd0);

    // flush with two in flight and a request pending
    drive(0, 1'b1, 2'd0, 32'h1, 32'h1, 3'd6); tick();
    drive(0, 1'b1, 2'd0, 32'h2, 32'h1, 3'd7); tick();
    drive(0, 1'b1, 2'd3, 32'h5, 32'h5, 3'd4);
    flush[0] = 1'b1;
    #1;
    chk("flush in_ready", 64'(in_ready[0]), 64'd0);
    chk("pre-flush inflight", 64'(infl3), 64'd2);
    tick();
    flush[0] = 1'b0; in_valid[0] = 1'b0;
    chk("post-flush inflight", 64'(infl3), 64'd0);
    tick(); chk("post-flush valid a", 64'(out_valid[0]), 64'd0);
    tick(); chk("post-flush valid b", 64'(out_valid[0]), 64'd0);

    // asynchronous reset mid-stream
    drive(0, 1'b1, 2'd3, 32'h10, 32'h20, 3'd1); tick();
    drive(0, 1'b1, 2'd3, 32'h10, 32'h20, 3'd2); tick();
    drive(0, 1'b1, 2'd3, 32'h10, 32'h20, 3'd3); tick();
    chk("pre-reset valid", 64'(out_valid[0]), 64'd1);
    chk("pre-reset result", 64'(result[0]), 64'h30);
    #2; rst = 1'b1; #1;
    chk("async rst valid", 64'(out_valid[0]), 64'd0);
    chk("async rst inflight", 64'(infl3), 64'd0);
    chk("async rst in_ready", 64'(in_ready[0]), 64'd0);
    tick(); tick();
    in_valid[0] = 1'b0;
    rst = 1'b0;
    tick(); chk("after rst valid", 64'(out_valid[0]), 64'd0);
    tick(); chk("after rst inflight", 64'(infl3), 64'd0);

    // DEPTH=1 latency, then random stress
    drive(1, 1'b1, 2'd3, 32'hFFFFFFFF, 32'h00000002, 3'd4); tick();
    in_valid[1] = 1'b0;
    chk("d1 valid", 64'(out_valid[1]), 64'd1);
    chk("d1 result", 64'(result[1]), 64'h1);
    chk("d1 id", 64'(id_out[1]), 64'd4);
    tick(); chk("d1 done", 64'(out_valid[1]), 64'd0);
    for (int n = 0; n < 400; n++) begin
      drive(1, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
            3'($urandom_range(0, 7)));
      out_ready[1] = $urandom_range(0, 3) != 0;
      flush[1]     = $urandom_range(0, 31) == 0;
      tick();
    end
    in_valid[1] = 1'b0; flush[1] = 1'b0; out_ready[1] = 1'b1;
    tick(); tick();
    chk("stress drained valid", 64'(out_valid[1]), 64'd0);
    chk("stress drained inflight", 64'(infl1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cvxif_delay_alu.md
CVXIF_DELAY_ALU -- requirements
Module: cvxif_delay_alu

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits (>=1).
REQ-002 Parameter DEPTH, default 1: pipeline latency in cycles (>=1).
REQ-003 Parameter ID_W, default 3: width of the instruction tag carried with each operation.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous and active-high.
REQ-006 flush_i  input  1  synchronous kill of all in-flight operations.
REQ-007 in_valid_i  input  1  operation request valid.
REQ-008 in_ready_o  output  1  block can accept a request this cycle.
REQ-009 op_i  input  2  operation select: 00 XOR, 01 AND, 10 OR, 11 ADD.
REQ-010 rs1_i  input  WIDTH  operand 1.
REQ-011 rs2_i  input  WIDTH  operand 2.
REQ-012 id_i  input  ID_W  request tag.
REQ-013 out_valid_o  output  1  result valid.
REQ-014 out_ready_i  input  1  consumer accepts result.
REQ-015 result_o  output  WIDTH  operation result.
REQ-016 id_o  output  ID_W  tag of the presented result.
REQ-017 inflight_o  output  $clog2(DEPTH+1)  number of valid pipeline stages.

Function
REQ-018 Request accepted when in_valid_i and in_ready_o are both high on a rising edge; result delivered when out_valid_o and out_ready_i are both high.
REQ-019 Result computed combinationally from the accepted operands and registered into stage 0; ADD is modulo 2^WIDTH, carry discarded.
REQ-020 Pipeline of DEPTH stages, each holding valid, result and id; out_valid_o/result_o/id_o driven from stage DEPTH-1.
REQ-021 Stage k advances when stage k+1 is empty or advancing (last stage advances on out_ready_i); otherwise it holds.
REQ-022 in_ready_o = (stage 0 empty or stage 0 advancing) and not flush_i; purely combinational, no in_valid_i dependency.
REQ-023 Unstalled latency: request accepted at edge N appears with out_valid_o high after edge N+DEPTH-1 (DEPTH=1: visible the cycle after acceptance).
REQ-024 Throughput one operation per cycle when out_ready_i held high, including DEPTH=1.
REQ-025 While out_valid_o high and out_ready_i low, result_o and id_o stay stable.
REQ-026 Pipeline full and out_ready_i low: all stages hold, in_ready_o low.
REQ-027 Full pipeline and out_ready_i high in same cycle: new request accepted (bubble-free).
REQ-028 flush_i high: all valid bits cleared next edge, no request accepted that cycle; flush wins over simultaneous accept and deliver.
REQ-029 inflight_o equals count of set stage valid bits; 0 after flush or reset, DEPTH when full.
REQ-030 Data registers of empty stages are don't-care internally but result_o/id_o read 0 when out_valid_o low.

Reset
REQ-031 rst_i high: all valid bits, data and id registers clear to 0 immediately, independent of clock.
REQ-032 Outputs during/after reset: out_valid_o 0, result_o 0, id_o 0, inflight_o 0, in_ready_o 1 once rst_i deasserted (0 while asserted).
REQ-033 Reset mid-operation discards all in-flight results; none delivered after release.

Structure
REQ-034 Package cvxif_delay_alu_pkg holds the op enum (XOR/AND/OR/ADD) and default WIDTH/DEPTH/ID_W constants.
REQ-035 One sub-module cvxif_delay_alu_stage: one elastic stage register (valid, data, id, hold/advance), instantiated DEPTH times by generate loop.
REQ-036 No multicycle or latch paths; ALU logic only ahead of stage 0.

Verification
REQ-037 DEPTH=3, ready high: XOR 0xFFFF0000^0x0F0F0F0F id 5 -> after 3 cycles 0xF0F00F0F, id_o 5, one-cycle out_valid_o.
REQ-038 ADD 0xFFFFFFFF+0x00000002 -> 0x00000001; AND 0xF0F0F0F0&0x3C3C3C3C -> 0x30303030; OR 0x1+0x2 -> 0x3 streamed back-to-back, in order, one per cycle.
REQ-039 DEPTH=3, out_ready_i low, 4 requests: 3 accepted, in_ready_o low, inflight_o 3, result_o stable; raise ready -> 4th accepted same cycle, all 4 delivered in order.
REQ-040 Flush with 2 in flight and in_valid_i high -> request not accepted, inflight_o 0 next cycle, no out_valid_o.
REQ-041 Assert rst_i asynchronously mid-stream -> out_valid_o/inflight_o 0 before next edge; no stale result after release.
REQ-042 DEPTH=1 random valid/ready stress against reference model: no loss, duplication or reordering of id/results.
